two_port_fifo: RTL and testbench

Single-clock synchronous FIFO built on `twoPortMem`. It adds pointer management, occupancy tracking, full/empty and programmable almost-full/almost-empty flags, a synchronous clear, and overflow/underflow error pulses. It sits between producer and consumer datapaths that previously drove `twoPortMem` addresses directly. Storage depth, width and mux factor pass straight through to the memory.

---
 rtl/two_port_fifo_pkg.sv | 22 ++
 rtl/two_port_fifo_mem.sv | 43 ++++
 rtl/two_port_fifo.sv | 132 +++++++++++++
 tb/tb_two_port_fifo.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/two_port_fifo_pkg.sv
// Shared helpers for the two_port_fifo slice: address sizing and status flag bundle.
package two_port_fifo_pkg;

   // Ceiling log2; clogb2(32)=5, clogb2(33)=6. Used for pointer and count widths.
   function automatic int unsigned clogb2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) begin
         r++;
      end
      return r;
   endfunction

   // Registered FIFO status flags, all derived from the next-state occupancy.
   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

endpackage

// File: rtl/two_port_fifo_mem.sv
// twoPortMem: simple dual-port RAM, one write port and one registered read port.
module twoPortMem
   import two_port_fifo_pkg::*;
#(
   parameter int unsigned addresses = 32,
   parameter int unsigned width = 8,
   parameter int unsigned muxFactor = 0,
   localparam int unsigned addressWidth = clogb2(addresses)
) (
   input  logic                    writeClk,
   input  logic                    writeEnable,
   input  logic [addressWidth-1:0] writeAddress,
   input  logic [width-1:0]        writeData,
   input  logic                    readClk,
   input  logic                    readEnable,
   input  logic [addressWidth-1:0] readAddress,
   output logic [width-1:0]        readData
);

   // Array rows hold muxCols words each; depth is rounded up to whole rows.
   localparam int unsigned muxCols = (muxFactor == 0) ? 1 : muxFactor;
   localparam int unsigned rows = (addresses + muxCols - 1) / muxCols;

   logic [width-1:0] mem_q [rows*muxCols];
   logic [width-1:0] read_data_q;

   // Write port: store data at the addressed word when enabled.
   always_ff @(posedge writeClk) begin
      if (writeEnable) begin
         mem_q[writeAddress] <= writeData;
      end
   end

   // Read port: registered read, output holds until the next enabled read.
   always_ff @(posedge readClk) begin
      if (readEnable) begin
         read_data_q <= mem_q[readAddress];
      end
   end

   assign readData = read_data_q;

endmodule

// File: rtl/two_port_fifo.sv
// two_port_fifo: single-clock FIFO wrapping twoPortMem with pointers, occupancy,
// full/empty/almost flags, synchronous clear and overflow/underflow pulses.
module two_port_fifo
   import two_port_fifo_pkg::*;
#(
   parameter int unsigned addresses = 32,
   parameter int unsigned width = 8,
   parameter int unsigned muxFactor = 0,
   parameter int unsigned almostFullLevel = addresses - 2,
   parameter int unsigned almostEmptyLevel = 2,
   localparam int unsigned addressWidth = clogb2(addresses),
   localparam int unsigned countWidth = clogb2(addresses + 1)
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  clear,
   input  logic                  writeEnable,
   input  logic [width-1:0]      writeData,
   input  logic                  readEnable,
   output logic [width-1:0]      readData,
   output logic                  readValid,
   output logic                  full,
   output logic                  empty,
   output logic                  almostFull,
   output logic                  almostEmpty,
   output logic [countWidth-1:0] count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [addressWidth-1:0] LastAddr = addressWidth'(addresses - 1);
   localparam logic [countWidth-1:0]   Depth    = countWidth'(addresses);
   localparam logic                    AfReset  = (almostFullLevel == 0);

   logic                    push_ok, pop_ok;
   logic [addressWidth-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
   logic [countWidth-1:0]   count_d, count_q;
   fifo_flags_t             flags_d, flags_q;
   logic                    read_valid_d, read_valid_q;
   logic                    overflow_d, overflow_q;
   logic                    underflow_d, underflow_q;

   // Acceptance: full/empty block their own request even if the other side is accepted.
   always_comb begin
      push_ok = writeEnable & ~flags_q.full & ~clear;
      pop_ok  = readEnable & ~flags_q.empty & ~clear;
   end

   // Next-state pointers and occupancy; clear wins over any push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + 1'b1;
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Flags and error pulses computed from next-state occupancy and current requests.
   always_comb begin
      flags_d.full         = (count_d == Depth);
      flags_d.empty        = (count_d == '0);
      flags_d.almost_full  = (32'(count_d) >= almostFullLevel);
      flags_d.almost_empty = (32'(count_d) <= almostEmptyLevel);
      read_valid_d         = pop_ok;
      overflow_d           = writeEnable & flags_q.full & ~clear;
      underflow_d          = readEnable & flags_q.empty & ~clear;
   end

   // Control state registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wr_ptr_q                <= '0;
         rd_ptr_q                <= '0;
         count_q                 <= '0;
         flags_q.full            <= 1'b0;
         flags_q.empty           <= 1'b1;
         flags_q.almost_full     <= AfReset;
         flags_q.almost_empty    <= 1'b1;
         read_valid_q            <= 1'b0;
         overflow_q              <= 1'b0;
         underflow_q             <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         flags_q      <= flags_d;
         read_valid_q <= read_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   twoPortMem #(
      .addresses (addresses),
      .width     (width),
      .muxFactor (muxFactor)
   ) u_mem (
      .writeClk     (clk),
      .writeEnable  (push_ok),
      .writeAddress (wr_ptr_q),
      .writeData    (writeData),
      .readClk      (clk),
      .readEnable   (pop_ok),
      .readAddress  (rd_ptr_q),
      .readData     (readData)
   );

   assign readValid   = read_valid_q;
   assign full        = flags_q.full;
   assign empty       = flags_q.empty;
   assign almostFull  = flags_q.almost_full;
   assign almostEmpty = flags_q.almost_empty;
   assign count       = count_q;
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;

endmodule

// File: tb/tb_two_port_fifo.sv
// Self-checking bench for two_port_fifo (32 x 8): vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_two_port_fifo;

   logic       clk = 1'b0;
   logic       resetN, clear, writeEnable, readEnable;
   logic [7:0] writeData, readData;
   logic       readValid, full, empty, almostFull, almostEmpty, overflow, underflow;
   logic [5:0] count;

   always #5 clk = ~clk;

   two_port_fifo #(
      .addresses        (32),
      .width            (8),
      .muxFactor        (0),
      .almostFullLevel  (30),
      .almostEmptyLevel (2)
   ) dut (
      .clk         (clk),
      .resetN      (resetN),
      .clear       (clear),
      .writeEnable (writeEnable),
      .writeData   (writeData),
      .readEnable  (readEnable),
      .readData    (readData),
      .readValid   (readValid),
      .full        (full),
      .empty       (empty),
      .almostFull  (almostFull),
      .almostEmpty (almostEmpty),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: FIFO contents as a queue, plus expectations for the last edge.
   logic [7:0] model_q[$];
   logic       exp_rv, exp_ov, exp_uf;
   logic [7:0] exp_rd;

   typedef struct {
      logic       c, w;
      logic [7:0] d;
      logic       r;
      int         cnt;
      logic       full, empty, af, ae, ov, uf, rv;
      logic [7:0] rd;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      int n;
      n = model_q.size();
      check({tag, " count"},       32'(count),       n);
      check({tag, " full"},        32'(full),        32'(n == 32));
      check({tag, " empty"},       32'(empty),       32'(n == 0));
      check({tag, " almostFull"},  32'(almostFull),  32'(n >= 30));
      check({tag, " almostEmpty"}, 32'(almostEmpty), 32'(n <= 2));
      check({tag, " readValid"},   32'(readValid),   32'(exp_rv));
      check({tag, " overflow"},    32'(overflow),    32'(exp_ov));
      check({tag, " underflow"},   32'(underflow),   32'(exp_uf));
      if (exp_rv) check({tag, " readData"}, 32'(readData), 32'(exp_rd));
   endtask

   task automatic step(input logic c, input logic w, input logic [7:0] d, input logic r,
                       input string tag);
      int n;
      @(negedge clk);
      clear = c; writeEnable = w; writeData = d; readEnable = r;
      n = model_q.size();
      exp_ov = w && (n == 32) && !c;
      exp_uf = r && (n == 0) && !c;
      exp_rv = r && (n > 0) && !c;
      if (c) begin
         model_q.delete();
      end else begin
         if (exp_rv) exp_rd = model_q.pop_front();
         if (w && n < 32) model_q.push_back(d);
      end
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   task automatic push_n(input int n, input int base, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 8'(base + i), 1'b0, tag);
   endtask

   task automatic pop_n(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b1, tag);
   endtask

   initial begin
      int idx, wp, rp;
      resetN = 1'b0; clear = 1'b0; writeEnable = 1'b0; readEnable = 1'b0; writeData = '0;
      exp_rv = 1'b0; exp_ov = 1'b0; exp_uf = 1'b0; exp_rd = '0;

      // reset values
      repeat (2) @(posedge clk);
      #1;
      check_model("reset");
      @(negedge clk);
      resetN = 1'b1;

      // vector table: c w d r | cnt full empty af ae ov uf rv rd
      vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[1] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[2] = '{1'b0, 1'b1, 8'hBB, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[3] = '{1'b0, 1'b1, 8'hCC, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA};
      vecs[5] = '{1'b0, 1'b1, 8'hDD, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hBB};
      vecs[6] = '{1'b1, 1'b1, 8'hEE, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[7] = '{1'b0, 1'b1, 8'h11, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11};
      for (int i = 0; i < 9; i++) begin
         step(vecs[i].c, vecs[i].w, vecs[i].d, vecs[i].r, "vec");
         check("vec tbl count",       32'(count),       vecs[i].cnt);
         check("vec tbl full",        32'(full),        32'(vecs[i].full));
         check("vec tbl empty",       32'(empty),       32'(vecs[i].empty));
         check("vec tbl almostFull",  32'(almostFull),  32'(vecs[i].af));
         check("vec tbl almostEmpty", 32'(almostEmpty), 32'(vecs[i].ae));
         check("vec tbl overflow",    32'(overflow),    32'(vecs[i].ov));
         check("vec tbl underflow",   32'(underflow),   32'(vecs[i].uf));
         check("vec tbl readValid",   32'(readValid),   32'(vecs[i].rv));
         if (vecs[i].rv) check("vec tbl readData", 32'(readData), 32'(vecs[i].rd));
      end

      // fill 0..31, almostFull from 30, full at 32, then overflow pulse
      for (int i = 0; i < 32; i++) begin
         step(1'b0, 1'b1, 8'(i), 1'b0, "fill");
         if (i == 28) check("fill af at 29", 32'(almostFull), 32'd0);
         if (i == 29) check("fill af at 30", 32'(almostFull), 32'd1);
      end
      check("fill full", 32'(full), 32'd1);
      check("fill count", 32'(count), 32'd32);
      step(1'b0, 1'b1, 8'hFF, 1'b0, "overflow");
      check("overflow pulse", 32'(overflow), 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b0, "overflow idle");
      check("overflow one cycle", 32'(overflow), 32'd0);

      // drain back-to-back, data in order, then underflow pulse
      for (int i = 0; i < 32; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1, "drain");
         check("drain data", 32'(readData), 32'(i));
      end
      check("drain empty", 32'(empty), 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b1, "underflow");
      check("underflow pulse", 32'(underflow), 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b0, "underflow idle");

      // wrap-around: push 3 / pop 3 with running index
      idx = 0;
      for (int it = 0; it < 40; it++) begin
         push_n(3, idx, "wrap push");
         idx += 3;
         pop_n(3, "wrap pop");
      end

      // simultaneous push+pop at count 5
      push_n(5, 100, "sim5 fill");
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(200 + i), 1'b1, "sim5");
      check("sim5 count", 32'(count), 32'd5);
      pop_n(5, "sim5 drain");

      // push+pop at full: pop accepted, push rejected
      push_n(32, 50, "simfull fill");
      step(1'b0, 1'b1, 8'h77, 1'b1, "simfull");
      check("simfull count", 32'(count), 32'd31);
      check("simfull overflow", 32'(overflow), 32'd1);
      pop_n(31, "simfull drain");

      // push+pop at empty: push accepted, pop rejected
      step(1'b0, 1'b1, 8'h5A, 1'b1, "simempty");
      check("simempty count", 32'(count), 32'd1);
      check("simempty underflow", 32'(underflow), 32'd1);
      pop_n(1, "simempty drain");

      // clear overrides push+pop
      push_n(10, 10, "clear fill");
      step(1'b1, 1'b1, 8'h99, 1'b1, "clear");
      check("clear count", 32'(count), 32'd0);
      check("clear readValid", 32'(readValid), 32'd0);

      // refill, pop in flight, then asynchronous reset between edges
      push_n(4, 60, "refill");
      step(1'b0, 1'b0, 8'h00, 1'b1, "pre-reset pop");
      #2;
      resetN = 1'b0;
      #1;
      check("async count",       32'(count),       32'd0);
      check("async empty",       32'(empty),       32'd1);
      check("async full",        32'(full),        32'd0);
      check("async almostFull",  32'(almostFull),  32'd0);
      check("async almostEmpty", 32'(almostEmpty), 32'd1);
      check("async readValid",   32'(readValid),   32'd0);
      check("async overflow",    32'(overflow),    32'd0);
      check("async underflow",   32'(underflow),   32'd0);
      model_q.delete();
      exp_rv = 1'b0; exp_ov = 1'b0; exp_uf = 1'b0;
      @(negedge clk);
      clear = 1'b0; writeEnable = 1'b0; readEnable = 1'b0;
      resetN = 1'b1;

      // randomized traffic with phase-varying bias to reach full and empty
      for (int ph = 0; ph < 6; ph++) begin
         case (ph % 3)
            0:       begin wp = 75; rp = 30; end
            1:       begin wp = 30; rp = 75; end
            default: begin wp = 55; rp = 55; end
         endcase
         for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 99) < wp),
                 8'($urandom),
                 ($urandom_range(0, 99) < rp),
                 "random");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
